// File: rtl/vga_scene_ctrl.sv
// vga_scene_ctrl: selects the background scene shown by the VGA display block.
// The next/prev push-buttons are synchronised and debounced. A requested scene
// change is queued and only committed at the start of a video frame (a falling
// edge of vga_vs), so the picture never switches mid-frame.
// Optional feature macro: VGA_SCENE_AUTO_EN (adds a slideshow that advances
// one scene every AUTO_FRAMES frames while mode_auto is high).
module vga_scene_ctrl #(
  parameter int NUM_SCENES      = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       vga_vs,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       mode_auto,
  output logic [2:0] choise,
  output logic       frame_tick,
  output logic       pending
);

  localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      LAST_SCENE = 3'(NUM_SCENES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  // Scene index arithmetic with wrap-around at both ends.
  function automatic logic [2:0] f_scene_inc(input logic [2:0] s);
    f_scene_inc = (s == LAST_SCENE) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] f_scene_dec(input logic [2:0] s);
    f_scene_dec = (s == 3'd0) ? LAST_SCENE : s - 3'd1;
  endfunction

  // Synchronisers; bit 0 = next button, bit 1 = prev button.
  logic            r_vs_s1, r_vs_s2, r_vs_d;
  logic [1:0]      r_btn_s1, r_btn_s2, r_btn_d;
  logic [1:0]      r_db_lvl;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      r_req;
  logic            r_fall;
  logic            r_frame_tick;
  state_t          r_state;
  logic            r_dir;
  logic            r_pending;
  logic [2:0]      r_choise;
  logic            w_vs_fall;
  logic            w_next;
  logic            w_prev;
  logic            w_auto_step;

  assign w_next    = r_req[0];
  assign w_prev    = r_req[1];
  assign w_vs_fall = r_vs_d & ~r_vs_s2;

  // Two-flop synchronisers for vsync and both buttons, plus a delayed copy for edge detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_vs_s1  <= 1'b1;
      r_vs_s2  <= 1'b1;
      r_vs_d   <= 1'b1;
      r_btn_s1 <= 2'b00;
      r_btn_s2 <= 2'b00;
      r_btn_d  <= 2'b00;
    end else begin
      r_vs_s1  <= vga_vs;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
      r_btn_s1 <= {btn_prev, btn_next};
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
    end
  end

  // Debounce each button and emit a one-cycle request on an accepted press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_db_lvl <= 2'b00;
      r_req    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_req[i] <= 1'b0;
        if (r_btn_s2[i] != r_btn_d[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_btn_s2[i] != r_db_lvl[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_cnt[i] <= '0;
            r_db_lvl[i] <= r_btn_s2[i];
            r_req[i]    <= r_btn_s2[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Frame start: register the detected vsync fall, then pulse frame_tick one cycle later.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_fall       <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_fall       <= w_vs_fall;
      r_frame_tick <= r_fall;
    end
  end

`ifdef VGA_SCENE_AUTO_EN
  localparam int              AF_W    = $clog2(AUTO_FRAMES + 1);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTO_FRAMES - 1);
  logic [AF_W-1:0] r_frame_cnt;

  assign w_auto_step = r_fall & mode_auto & (r_frame_cnt == AF_LAST) & (r_req == 2'b00);

  // Slideshow frame counter; restarts when auto mode is off or a button is used.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_frame_cnt <= '0;
    end else if (!mode_auto || (r_req != 2'b00)) begin
      r_frame_cnt <= '0;
    end else if (r_fall) begin
      r_frame_cnt <= (r_frame_cnt == AF_LAST) ? '0 : r_frame_cnt + 1'b1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end
`else
  logic w_unused_auto;
  assign w_auto_step   = 1'b0;
  assign w_unused_auto = mode_auto ^ (AUTO_FRAMES < 1);
`endif

  // IDLE/PEND scheduler: queue the latest request, commit it at frame start, cancel on a next+prev clash.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_dir     <= 1'b0;
      r_pending <= 1'b0;
      r_choise  <= 3'd0;
    end else begin
      if (r_fall && !(w_next && w_prev)) begin
        if (r_state == ST_PEND) begin
          r_choise <= r_dir ? f_scene_inc(r_choise) : f_scene_dec(r_choise);
        end else if (w_auto_step) begin
          r_choise <= f_scene_inc(r_choise);
        end else begin
          r_choise <= r_choise;
        end
      end else begin
        r_choise <= r_choise;
      end

      if (w_next && w_prev) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
      end else if (w_next || w_prev) begin
        r_state   <= ST_PEND;
        r_pending <= 1'b1;
        r_dir     <= w_next;
      end else if (r_fall) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
      end else begin
        r_state   <= r_state;
        r_pending <= r_pending;
      end
    end
  end

  assign choise     = r_choise;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: doc/vga_scene_ctrl.md
VGA_SCENE_CTRL -- requirements
Module: vga_scene_ctrl

Interface
REQ-001 SHALL have parameter NUM_SCENES, default 5; number of background scenes, legal 2..8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; stable-level cycles before a button change is accepted (20 ms at 50 MHz).
REQ-003 SHALL have parameter AUTO_FRAMES, default 300; frames per scene in auto mode.
REQ-004 SHALL have port sys_clk, input, 1, system clock; the only clock.
REQ-005 SHALL have port sys_rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port vga_vs, input, 1, active-low field sync from the VGA driver, asynchronous to sys_clk.
REQ-007 SHALL have port btn_next, input, 1, raw push-button, active-high, asynchronous.
REQ-008 SHALL have port btn_prev, input, 1, raw push-button, active-high, asynchronous.
REQ-009 SHALL have port mode_auto, input, 1, level; 1 = slideshow mode.
REQ-010 SHALL have port choise, output, 3, scene index to the background display block.
REQ-011 SHALL have port frame_tick, output, 1, one-cycle pulse per frame start.
REQ-012 SHALL have port pending, output, 1, high while a scene change waits for frame start.

Function
REQ-013 SHALL pass vga_vs, btn_next and btn_prev each through a 2-flop synchronizer.
REQ-014 SHALL debounce each button: per-button counter clears on any synced-level change; debounced level updates only when the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 SHALL generate a one-cycle request on each debounced 0->1 transition; releases generate nothing.
REQ-016 SHALL run FSM IDLE/PEND: IDLE->PEND on any request; PEND->IDLE on frame start; pending = (state == PEND).
REQ-017 SHALL hold a direction register in PEND; a later request overwrites it (latest wins).
REQ-018 SHALL cancel a queued change when next and prev requests arrive in the same cycle: state->IDLE, choise unchanged.
REQ-019 SHALL define frame start as a 1->0 transition of synced vga_vs; frame_tick asserts in the cycle after the transition is detected.
REQ-020 SHALL set frame_tick exactly 3 sys_clk edges after the first edge sampling vga_vs low; choise updates on the same edge as frame_tick.
REQ-021 SHALL change choise only at frame start; choise never changes mid-frame.
REQ-022 SHALL wrap choise: next from NUM_SCENES-1 -> 0; prev from 0 -> NUM_SCENES-1; all other steps +/-1.
REQ-023 SHALL accept a request arriving in the same cycle as frame start only at the following frame start.
REQ-024 SHALL keep choise in 0..NUM_SCENES-1 at all times.

Reset
REQ-025 SHALL on sys_rst set choise=0, frame_tick=0, pending=0, state=IDLE, all counters=0, debounced levels=0, vga_vs sync flops=1.
REQ-026 SHALL discard any queued change when reset is asserted mid-operation; after release no change occurs until a new request.

Configuration
REQ-027 SHALL implement auto mode only when macro VGA_SCENE_AUTO_EN is defined.
REQ-028 With VGA_SCENE_AUTO_EN: counter counts frame starts while mode_auto=1; at AUTO_FRAMES-1 it clears and raises an internal next request; the counter clears on mode_auto=0 or any button request.
REQ-029 Without VGA_SCENE_AUTO_EN: mode_auto ignored, frame counter absent, AUTO_FRAMES unused.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_SCENES=5)
REQ-030 Reset, btn_next held 10 cycles, then 3 vsync falls -> choise 0->1 at first frame_tick only; pending high from request to that tick.
REQ-031 btn_next glitch high 2 cycles -> no request; pending stays 0; choise stays 0.
REQ-032 choise=4, next, frame start -> choise=0; then prev, frame start -> choise=4.
REQ-033 next then prev in same frame -> choise decrements once; simultaneous next+prev requests -> pending drops, choise unchanged.
REQ-034 vga_vs falls at cycle N -> frame_tick and choise update at edge N+3; sys_rst asserted while pending -> choise=0, pending=0, no change at next frame start.
REQ-035 VGA_SCENE_AUTO_EN defined, mode_auto=1, 7 frames -> choise 0->1 at frame 3, 1->2 at frame 6; macro undefined -> choise stays 0.
